// File: rtl/pipeline_pkg.sv
// pipeline_pkg: opcodes, control-field layout and MEM-stage state shared by the pipeline.
package pipeline_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 5;
  localparam int CTRL_VALID = 4;
  localparam int CTRL_OP_MSB = 3;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8;
  localparam logic [3:0] OP_SLT = 4'h9;
  localparam logic [3:0] OP_LUI = 4'hA;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_LOAD = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_STORE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic {ST_IDLE, ST_BUSY} mem_state_t;
  function automatic logic is_mem_op(input logic [CTRL_VALID:0] ctrl);
    return ctrl[CTRL_VALID] && (ctrl[CTRL_OP_MSB:0] == OP_LOAD || ctrl[CTRL_OP_MSB:0] == OP_STORE);
  endfunction
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts BUSY cycles without ack and flags the cycle that must force completion.
module mem_watchdog #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ack,
  output logic expire
);
  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);
  logic [W-1:0] cnt;
  // Idle clears the count, so every BUSY entry starts from zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= !busy ? '0 : (ack ? cnt : cnt + 1'b1);
  assign expire = busy && cnt == LAST;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage; ALU ops retire in one cycle, LOAD/STORE via req/ack port.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        control_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  dest_index_in,
  input  logic              write_en_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_write_en,
  output logic [REG_W-1:0]  wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);
  mem_state_t state, state_next;
  logic [REG_W-1:0] dest_q;
  logic is_mem, is_store, accept_mem, finish, expire, timed_out;
  assign is_mem = is_mem_op(control_in);
  assign is_store = control_in[CTRL_OP_MSB:0] == OP_STORE;
`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(.CYCLES(MEM_TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .rst_n(rst_n),
    .busy(state == ST_BUSY),
    .ack(mem_ack),
    .expire(expire)
  );
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(MEM_TIMEOUT_CYCLES);
  assign expire = 1'b0;
`endif
  // An ack in the expiry cycle wins, so the access completes normally.
  assign timed_out = expire && !mem_ack;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    stall = 1'b0;
    accept_mem = 1'b0;
    finish = 1'b0;
    if (state == ST_IDLE) begin
      stall = is_mem;
      accept_mem = is_mem;
      state_next = is_mem ? ST_BUSY : ST_IDLE;
    end else begin
      finish = mem_ack || expire;
      stall = !finish;
      state_next = finish ? ST_IDLE : ST_BUSY;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      dest_q <= '0;
      wb_valid <= 1'b0;
      wb_write_en <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
      mem_err <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept_mem) begin
        mem_req <= 1'b1;
        mem_we <= is_store;
        mem_addr <= result_in;
        mem_wdata <= store_data_in;
        dest_q <= dest_index_in;
      end else if (finish) begin
        mem_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_dest <= dest_q;
        wb_write_en <= !mem_we && !timed_out;
        wb_data <= (mem_we || timed_out) ? mem_addr : mem_rdata;
        mem_err <= mem_err || timed_out;
      end else if (state == ST_IDLE && control_in[CTRL_VALID]) begin
        wb_valid <= 1'b1;
        wb_dest <= dest_index_in;
        wb_write_en <= write_en_in;
        wb_data <= result_in;
      end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed stimulus with a queue scoreboard checked by an independent wb monitor.
module tb_memory_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] control_in = '0;
  logic [15:0] result_in = '0, store_data_in = '0, mem_rdata = '0;
  logic [4:0] dest_index_in = '0;
  logic write_en_in = 1'b0, mem_ack = 1'b0;
  logic stall, mem_req, mem_we, wb_valid, wb_write_en, mem_err;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic [4:0] wb_dest;
  typedef struct {
    logic we;
    logic [4:0] dest;
    logic [15:0] data;
    logic chk_data;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 16;
`endif
  memory_stage #(.MEM_TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .control_in(control_in), .result_in(result_in),
    .store_data_in(store_data_in), .dest_index_in(dest_index_in), .write_en_in(write_en_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
    .wb_write_en(wb_write_en), .wb_dest(wb_dest), .wb_data(wb_data), .mem_err(mem_err)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t mk(input logic we, input logic [4:0] dest, input logic [15:0] data, input logic chk);
    exp_t r;
    r.we = we;
    r.dest = dest;
    r.data = data;
    r.chk_data = chk;
    return r;
  endfunction
  always @(negedge clk)
    if (rst_n && wb_valid) begin
      if (q.size() == 0) check("unexpected_wb_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("wb_write_en", 32'(wb_write_en), 32'(e.we));
        check("wb_dest", 32'(wb_dest), 32'(e.dest));
        if (e.chk_data) check("wb_data", 32'(wb_data), 32'(e.data));
      end
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] ctrl, input logic [15:0] res, input logic [15:0] sd, input logic [4:0] dest, input logic we);
    control_in = ctrl;
    result_in = res;
    store_data_in = sd;
    dest_index_in = dest;
    write_en_in = we;
  endtask
  // Presents a memory op held while stalled; ack comes k cycles after mem_req rises.
  task automatic mem_op(input logic [4:0] ctrl, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [4:0] dest, input int k, input logic [15:0] rdata);
    int nreq = 0;
    int nstall = 0;
    cyc();
    drive(ctrl, addr, wdata, dest, 1'b1);
    for (int c = 0; c <= k + 1; c++) begin
      if (c > 0) cyc();
      if (c == k + 1) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
      nreq += int'(mem_req);
      nstall += int'(stall);
      if (c == 1) begin
        check("mem_we", 32'(mem_we), 32'(ctrl[3:0] == 4'hE));
        check("mem_addr", 32'(mem_addr), 32'(addr));
        if (ctrl[3:0] == 4'hE) check("mem_wdata", 32'(mem_wdata), 32'(wdata));
      end
      if (c == k + 1) check("stall_in_ack_cycle", 32'(stall), 32'd0);
    end
    check("mem_req_cycles", 32'(nreq), 32'(k + 1));
    check("stall_cycles", 32'(nstall), 32'(k + 1));
  endtask
  initial begin
    #12;
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_write_en", 32'(wb_write_en), 0);
    check("rst_wb_dest", 32'(wb_dest), 0);
    check("rst_wb_data", 32'(wb_data), 0);
    check("rst_mem_err", 32'(mem_err), 0);
    check("rst_stall", 32'(stall), 0);
    rst_n = 1'b1;
    cyc();
    drive(5'b1_0010, 16'h1234, 16'h0, 5'd3, 1'b1);
    q.push_back(mk(1'b1, 5'd3, 16'h1234, 1'b1));
    @(negedge clk);
    check("add_stall", 32'(stall), 0);
    cyc();
    drive(5'b0, 16'hFFFF, 16'h0, 5'd31, 1'b0);
    @(negedge clk);
    check("add_wb_valid", 32'(wb_valid), 1);
    check("nop_stall", 32'(stall), 0);
    cyc();
    @(negedge clk);
    check("wb_valid_pulse", 32'(wb_valid), 0);
    check("nop_hold_data", 32'(wb_data), 32'h1234);
    q.push_back(mk(1'b1, 5'd5, 16'hBEEF, 1'b1));
    mem_op(5'b1_1100, 16'h0040, 16'h0, 5'd5, 3, 16'hBEEF);
    cyc();
    mem_ack = 1'b0;
    drive(5'b0, 16'h0, 16'h0, 5'd0, 1'b0);
    @(negedge clk);
    check("load_wb_valid", 32'(wb_valid), 1);
    q.push_back(mk(1'b0, 5'd7, 16'h0010, 1'b1));
    mem_op(5'b1_1110, 16'h0010, 16'h00AA, 5'd7, 0, 16'h0);
    cyc();
    mem_ack = 1'b0;
    drive(5'b0, 16'h0, 16'h0, 5'd0, 1'b0);
    @(negedge clk);
    check("store_wb_valid", 32'(wb_valid), 1);
    q.push_back(mk(1'b1, 5'd9, 16'hCAFE, 1'b1));
    q.push_back(mk(1'b1, 5'd10, 16'h5555, 1'b1));
    mem_op(5'b1_1100, 16'h0080, 16'h0, 5'd9, 1, 16'hCAFE);
    cyc();
    mem_ack = 1'b0;
    drive(5'b1_0011, 16'h5555, 16'h0, 5'd10, 1'b1);
    @(negedge clk);
    check("load2_wb_valid", 32'(wb_valid), 1);
    check("add_after_load_stall", 32'(stall), 0);
    cyc();
    drive(5'b0, 16'h0, 16'h0, 5'd0, 1'b0);
    @(negedge clk);
    check("add_after_load_wb_valid", 32'(wb_valid), 1);
    cyc();
    @(negedge clk);
    check("add_after_load_single", 32'(wb_valid), 0);
    cyc();
    drive(5'b1_1100, 16'h0100, 16'h0, 5'd12, 1'b1);
    cyc();
    @(negedge clk);
    check("busy_mem_req", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_mem_req", 32'(mem_req), 0);
    drive(5'b0, 16'h0, 16'h0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    mem_ack = 1'b1;
    mem_rdata = 16'h1111;
    @(negedge clk);
    check("stale_ack_stall", 32'(stall), 0);
    cyc();
    mem_ack = 1'b0;
    @(negedge clk);
    check("stale_ack_no_wb", 32'(wb_valid), 0);
`ifdef MEM_TIMEOUT_EN
    begin
      int nreq = 0;
      q.push_back(mk(1'b0, 5'd6, 16'h0, 1'b0));
      cyc();
      drive(5'b1_1100, 16'h0200, 16'h0, 5'd6, 1'b1);
      for (int c = 0; c <= int'(TO); c++) begin
        if (c > 0) cyc();
        @(negedge clk);
        nreq += int'(mem_req);
      end
      check("timeout_stall", 32'(stall), 0);
      check("timeout_req_cycles", 32'(nreq), 32'(TO));
      cyc();
      drive(5'b1_0010, 16'h0042, 16'h0, 5'd4, 1'b1);
      q.push_back(mk(1'b1, 5'd4, 16'h0042, 1'b1));
      @(negedge clk);
      check("timeout_wb_valid", 32'(wb_valid), 1);
      check("timeout_mem_err", 32'(mem_err), 1);
      check("timeout_req_low", 32'(mem_req), 0);
      cyc();
      drive(5'b0, 16'h0, 16'h0, 5'd0, 1'b0);
      @(negedge clk);
      check("mem_err_sticky", 32'(mem_err), 1);
    end
`else
    check("mem_err_tied_low", 32'(mem_err), 0);
`endif
    repeat (3) cyc();
    check("scoreboard_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage, directly downstream of the execute stage. Retires ALU results to writeback in one cycle and performs LOAD/STORE through a variable-latency data-memory request/acknowledge port. Holds the upstream pipeline with `stall` while a memory access is outstanding.

## Interface
- `MEM_TIMEOUT_CYCLES`, default 16: number of BUSY cycles without `mem_ack` before the access is aborted. Used only with the macro enabled.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `control_in`  in  5  `[4]` = valid, `[3:0]` = opcode (LOAD 4'hC, STORE 4'hE).
- `result_in`  in  16  ALU result; memory address for LOAD/STORE.
- `store_data_in`  in  16  STORE write data.
- `dest_index_in`  in  5  destination register index.
- `write_en_in`  in  1  register-write enable from execute.
- `stall`  out  1  combinational; upstream holds its outputs while 1.
- `mem_req`, `mem_we`  out  1  request strobe and write enable.
- `mem_addr`, `mem_wdata`  out  16  request address and write data.
- `mem_rdata`  in  16  read data, valid in the `mem_ack` cycle.
- `mem_ack`  in  1  single-cycle completion.
- `wb_valid`, `wb_write_en`  out  1  retire strobe and register write.
- `wb_dest`  out  5  destination index.
- `wb_data`  out  16  writeback value.
- `mem_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY. A memory op is an input with valid=1 and opcode LOAD or STORE.
- IDLE, valid non-memory op: register `result_in`, `dest_index_in` and `write_en_in` to the `wb_*` outputs. Set `wb_valid`=1.
- IDLE, valid=0 (NOP): `wb_valid`=0. All other `wb_*` outputs hold their values.
- IDLE, memory op:
  - `stall`=1.
  - On the clock edge: latch the address, write data, destination and opcode.
  - Registered outputs: `mem_req`=1, `mem_we`=(STORE). Enter BUSY.
  - `wb_valid`=0 in the next cycle.
- BUSY: `mem_req`/`mem_addr`/`mem_we`/`mem_wdata` are held stable. `stall`=!`mem_ack`.
- BUSY with `mem_ack`=1, on the clock edge:
  - `mem_req`=0 and `wb_valid`=1; go to IDLE.
  - LOAD: `wb_data`=`mem_rdata`, `wb_write_en`=1.
  - STORE: `wb_write_en`=0 and `wb_data`=address.
- `mem_ack` while IDLE is ignored.
- `mem_addr` is used unmodified; no alignment or width checks.

## Timing
- Reset: state IDLE. All of these outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `wb_valid`, `wb_write_en`, `wb_dest`, `wb_data`, `mem_err`. `stall` evaluates to 0 when the input is invalid.
- Reset is asynchronous. Asserting it while BUSY drops `mem_req` immediately and abandons the access. No `wb_valid` is produced for it.
- Non-memory op presented in cycle N: `wb_valid` in cycle N+1.
- Memory op presented in cycle N:
  - `mem_req` is high from cycle N+1.
  - `mem_ack` arrives in cycle N+1+k, where k≥0.
  - `wb_valid` is in cycle N+2+k.
  - `stall` is high in cycles N..N+k and low in the ack cycle, so the upstream advances on the ack edge.
- A new op is accepted in cycle N+2+k. Back-to-back throughput is therefore one memory op per k+2 cycles.
- `wb_valid` is a single-cycle pulse per retired op.

## Configuration
- `MEM_TIMEOUT_EN` defined: a counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When the count reaches `MEM_TIMEOUT_CYCLES`, treat that cycle as a forced completion: `stall`=0, then `mem_req`=0, `wb_valid`=1, `wb_write_en`=0, `mem_err`=1.
  - `mem_err` stays set until reset.
  - An ack in the same cycle takes priority over the timeout.
- `MEM_TIMEOUT_EN` undefined: no counter. BUSY waits indefinitely and `mem_err` is tied to 0.

## Structure
- Shared `pipeline_pkg`: opcode constants (the full 4-bit set used by execute), the control-field bit positions, and the MEM state enum.
- One sub-module, `mem_watchdog`, holds the timeout counter. It is instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- ADD pass-through: control_in=5'b1_0010, result_in=16'h1234, dest=3, write_en=1. Next cycle: `wb_valid`=1, `wb_data`=16'h1234, `wb_dest`=3, `wb_write_en`=1; `stall`=0 throughout.
- LOAD: addr 16'h0040, dest=5, `mem_ack` 3 cycles after `mem_req` rises, `mem_rdata`=16'hBEEF.
  - `mem_req` is high for 4 cycles and `stall` for 4 cycles.
  - Then `wb_data`=16'hBEEF, `wb_write_en`=1, `wb_dest`=5.
- STORE with k=0: addr 16'h0010, data 16'h00AA, ack in the first `mem_req` cycle.
  - `mem_we`=1, `mem_wdata`=16'h00AA, one cycle of `mem_req`.
  - `wb_valid`=1 with `wb_write_en`=0 two cycles after presentation.
- LOAD (k=1) followed by ADD: ADD is accepted in the cycle after the ack. Its `wb_valid` follows the LOAD's `wb_valid` by exactly one cycle; no op is lost or duplicated.
- `rst_n` pulsed low during BUSY: `mem_req` drops asynchronously. An `mem_ack` after reset release produces no `wb_valid`.
- `MEM_TIMEOUT_EN`, `MEM_TIMEOUT_CYCLES`=8, LOAD with no ack: `mem_req` is high for 8 cycles, then `mem_err`=1 and `wb_valid`=1 with `wb_write_en`=0. `mem_err` stays at 1 after a subsequent ADD.
